// File: rtl/fp_div_mant_seq.sv
// Radix-2 restoring mantissa divider for the single-precision divide path.
// Produces one quotient bit per clock, with valid/ready handshakes on both sides.
module fp_div_mant_seq #(
   parameter int MW = 24,
   parameter int QW = 26
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] dividend_mant,
   input  logic [MW-1:0] divisor_mant,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] quo_mant,
   output logic          sticky,
   output logic          dbz
);

   localparam int CW = $clog2(QW + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [MW+1:0] rem_q, rem_d;
   logic [MW-1:0] div_q, div_d;
   logic [QW-1:0] q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [QW-1:0] quo_q, quo_d;
   logic          sticky_q, sticky_d;
   logic          dbz_q, dbz_d;

   logic [MW+1:0] divExt;
   logic [MW+1:0] remSub;
   logic          remGeq;
   logic [MW+1:0] remKeep;
   logic [QW-1:0] qShift;

   // One restoring step: the partial remainder stays below 2*divisor, so MW+2 bits never overflow.
   assign divExt  = {2'b00, div_q};
   assign remSub  = rem_q - divExt;
   assign remGeq  = (rem_q >= divExt);
   assign remKeep = remGeq ? remSub : rem_q;
   assign qShift  = {q_q[QW-2:0], remGeq};

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      div_d    = div_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      sticky_d = sticky_q;
      dbz_d    = dbz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               div_d = divisor_mant;
               rem_d = {2'b00, dividend_mant};
               q_d   = '0;
               cnt_d = '0;
               if (divisor_mant == '0) begin
                  state_d  = DONE;
                  quo_d    = '1;
                  sticky_d = 1'b0;
                  dbz_d    = 1'b1;
               end else begin
                  state_d = BUSY;
                  dbz_d   = 1'b0;
               end
            end
         end
         BUSY: begin
            q_d   = qShift;
            rem_d = {remKeep[MW:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            // Sticky reflects the remainder before the final shift.
            if (cnt_q == CW'(QW - 1)) begin
               quo_d    = qShift;
               sticky_d = (remKeep != '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         div_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         quo_q    <= '0;
         sticky_q <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         sticky_q <= sticky_d;
         dbz_q    <= dbz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quo_mant  = quo_q;
   assign sticky    = sticky_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_fp_div_mant_seq.sv
// Bench for fp_div_mant_seq: directed divides checked against an arithmetic
// reference model, covering divide-by-zero, backpressure and mid-divide reset.
module tb_fp_div_mant_seq;

   localparam int MW = 24;
   localparam int QW = 26;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] dividend;
   logic [MW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quo_mant;
   logic          sticky;
   logic          dbz;

   int            checks = 0;
   int            errors = 0;

   logic          expValid = 1'b0;
   logic [QW-1:0] expQuo;
   logic          expSticky;
   logic          expDbz;

   fp_div_mant_seq #(.MW(MW), .QW(QW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .dividend_mant (dividend),
      .divisor_mant  (divisor),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .quo_mant      (quo_mant),
      .sticky        (sticky),
      .dbz           (dbz)
   );

   always #5 clk = ~clk;

   // Reference: floor(a * 2^(QW-1) / b), sticky when that division leaves a remainder.
   function automatic void modelDiv(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                    output logic [QW-1:0] q, output logic s, output logic z);
      longint unsigned num;
      num = longint'(a) << (QW - 1);
      if (b == '0) begin
         q = '1;
         s = 1'b0;
         z = 1'b1;
      end else begin
         q = QW'(num / longint'(b));
         s = ((num % longint'(b)) != 0);
         z = 1'b0;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Whenever a result is presented it must match the model's expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         checkOutput("out_valid_expected", {31'b0, out_valid}, {31'b0, expValid});
         if (expValid) begin
            checkOutput("quo_mant", 32'(quo_mant), 32'(expQuo));
            checkOutput("sticky", {31'b0, sticky}, {31'b0, expSticky});
            checkOutput("dbz", {31'b0, dbz}, {31'b0, expDbz});
         end
      end
   end

   task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                input int holdCycles, input string tag);
      int            waitCnt;
      int            lat;
      logic [QW-1:0] q;
      logic          s;
      logic          z;
      waitCnt = 0;
      while (!in_ready && waitCnt < 50) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      if (!in_ready) begin
         checkOutput({tag, "_in_ready_timeout"}, {31'b0, in_ready}, 32'd1);
         return;
      end
      @(negedge clk);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      dividend  = MW'($urandom);
      divisor   = MW'($urandom);
      modelDiv(a, b, q, s, z);
      expQuo    = q;
      expSticky = s;
      expDbz    = z;
      expValid  = 1'b1;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), z ? 32'd0 : 32'(QW));
      repeat (holdCycles) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = 24'h800000;
         divisor  = 24'h800000;
         checkOutput({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      expValid  = 1'b0;
      checkOutput({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
      checkOutput({tag, "_quo_hold"}, 32'(quo_mant), 32'(q));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [QW-1:0] pq;
      logic          ps;
      logic          pz;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      modelDiv(24'h800000, 24'h800000, pq, ps, pz);
      checkOutput("model_1_over_1", 32'(pq), 32'h2000000);
      modelDiv(24'h800000, 24'hC00000, pq, ps, pz);
      checkOutput("model_1_over_1p5", 32'(pq), 32'h1555555);
      checkOutput("model_1_over_1p5_sticky", {31'b0, ps}, 32'd1);
      modelDiv(24'hFFFFFF, 24'h800000, pq, ps, pz);
      checkOutput("model_max_ratio", 32'(pq), 32'h3FFFFFC);
      modelDiv(24'h9A0000, 24'h000000, pq, ps, pz);
      checkOutput("model_dbz_quo", 32'(pq), 32'h3FFFFFF);
      checkOutput("model_dbz_flag", {31'b0, pz}, 32'd1);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_quo", 32'(quo_mant), 32'd0);
      checkOutput("reset_sticky", {31'b0, sticky}, 32'd0);
      checkOutput("reset_dbz", {31'b0, dbz}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);

      applyStimulus(24'h800000, 24'h800000, 0, "div_1_1");
      applyStimulus(24'hC00000, 24'h800000, 0, "div_1p5_1");
      applyStimulus(24'hFFFFFF, 24'h800000, 0, "div_max");
      applyStimulus(24'h800000, 24'hC00000, 0, "div_1_1p5");
      applyStimulus(24'h9A0000, 24'h000000, 0, "div_by_zero");
      applyStimulus(24'h800000, 24'h800000, 0, "div_after_dbz");
      applyStimulus(24'h000000, 24'h800000, 0, "div_zero_dividend");
      applyStimulus(24'hABCDEF, 24'hF12345, 0, "div_mixed_a");
      applyStimulus(24'hFFFFFF, 24'hFFFFFF, 0, "div_equal_max");
      applyStimulus(24'h800000, 24'hFFFFFF, 0, "div_min_ratio");
      applyStimulus(24'hC00000, 24'h800000, 5, "backpressure");

      // Abort a divide after ten steps; the result registers must clear at once.
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 24'h800000;
      divisor  = 24'h800000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      checkOutput("midreset_busy", {31'b0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midreset_quo", 32'(quo_mant), 32'd0);
      checkOutput("midreset_sticky", {31'b0, sticky}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("midreset_no_result", {31'b0, out_valid}, 32'd0);
      applyStimulus(24'h800000, 24'hC00000, 0, "after_reset");

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
